// File: rtl/led_frame_sequencer_if.sv
// Bundle between the frame sequencer and the color drivers / LED chip pins.
// The master side is the sequencer. The slave side is the driver bank or a bench.
interface led_frame_sequencer_if;
  logic       enable;
  logic       brightness_req;
  logic [7:0] pwm_time;
  logic       load_led_vals;
  logic       load_brightness;
  logic       shift;
  logic       serial_clk;
  logic       latch;
  logic       mode_sel;
  logic       busy;
  logic       pwm_cycle_done;

  modport master (
    input  enable, brightness_req,
    output pwm_time, load_led_vals, load_brightness, shift,
           serial_clk, latch, mode_sel, busy, pwm_cycle_done
  );

  modport slave (
    output enable, brightness_req,
    input  pwm_time, load_led_vals, load_brightness, shift,
           serial_clk, latch, mode_sel, busy, pwm_cycle_done
  );
endinterface

// File: rtl/led_frame_sequencer.sv
// Steps the shared PWM time base and sequences load/shift/latch for the color drivers.
// Every output is registered. Outputs are decoded from the next-state values so they line up with the state.
module led_frame_sequencer #(
  parameter int SHIFT_BITS   = 16,
  parameter int CLK_DIV      = 2,
  parameter int LATCH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  led_frame_sequencer_if.master bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] SHIFT_LO = 3'd2;
  localparam logic [2:0] SHIFT_HI = 3'd3;
  localparam logic [2:0] LATCH    = 3'd4;

  localparam int CNT_MAX = (CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int BIT_W   = $clog2(SHIFT_BITS) + 1;

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(SHIFT_BITS - 1);

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic             pending_reg, pending_next;
  logic             mode_reg, mode_next;
  logic [7:0]       pwm_reg, pwm_next;
  logic             load_led_reg, load_led_next;
  logic             load_bri_reg, load_bri_next;
  logic             shift_reg, shift_next;
  logic             sclk_reg, sclk_next;
  logic             latch_reg, latch_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             latch_done;
  logic             entering_load;
  logic             pwm_step;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    latch_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.enable) begin
          state_next = LOAD;
          cnt_next   = '0;
        end
      end
      LOAD: begin
        state_next   = SHIFT_LO;
        cnt_next     = '0;
        bit_cnt_next = '0;
      end
      SHIFT_LO: begin
        if (cnt_reg == DIV_LAST) begin
          state_next = SHIFT_HI;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      SHIFT_HI: begin
        if (cnt_reg == DIV_LAST) begin
          cnt_next     = '0;
          bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          state_next   = (bit_cnt_reg == BIT_LAST) ? LATCH : SHIFT_LO;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      LATCH: begin
        if (cnt_reg == LATCH_LAST) begin
          latch_done = 1'b1;
          cnt_next   = '0;
          state_next = bus.enable ? LOAD : IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // A request on the LOAD-entry edge or later wins over the clear, so a late request is never lost.
  always_comb begin
    entering_load = (state_next == LOAD);
    pending_next  = bus.brightness_req | (pending_reg & ~entering_load);
    if (entering_load)
      mode_next = pending_reg;
    else if (state_next == IDLE)
      mode_next = 1'b0;
    else
      mode_next = mode_reg;
    load_bri_next = entering_load & pending_reg;
    load_led_next = entering_load & ~pending_reg;
    shift_next    = (state_next == SHIFT_HI) && (cnt_next == DIV_LAST);
    sclk_next     = (state_next == SHIFT_HI);
    latch_next    = (state_next == LATCH);
    busy_next     = (state_next != IDLE);
    pwm_step      = latch_done & ~mode_reg;
    pwm_next      = pwm_reg + {7'd0, pwm_step};
    done_next     = pwm_step && (pwm_reg == 8'hFF);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bit_cnt_reg  <= '0;
      pending_reg  <= 1'b1;
      mode_reg     <= 1'b0;
      pwm_reg      <= 8'd0;
      load_led_reg <= 1'b0;
      load_bri_reg <= 1'b0;
      shift_reg    <= 1'b0;
      sclk_reg     <= 1'b0;
      latch_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      pending_reg  <= pending_next;
      mode_reg     <= mode_next;
      pwm_reg      <= pwm_next;
      load_led_reg <= load_led_next;
      load_bri_reg <= load_bri_next;
      shift_reg    <= shift_next;
      sclk_reg     <= sclk_next;
      latch_reg    <= latch_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign bus.pwm_time        = pwm_reg;
  assign bus.load_led_vals   = load_led_reg;
  assign bus.load_brightness = load_bri_reg;
  assign bus.shift           = shift_reg;
  assign bus.serial_clk      = sclk_reg;
  assign bus.latch           = latch_reg;
  assign bus.mode_sel        = mode_reg;
  assign bus.busy            = busy_reg;
  assign bus.pwm_cycle_done  = done_reg;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench for led_frame_sequencer: step shape, PWM counting, brightness requests,
// enable drop and mid-step reset, with hand-derived expectations for the default parameters.
module tb_led_frame_sequencer;
  logic clk;
  logic reset;

  led_frame_sequencer_if bus();

  led_frame_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_count = 0;

  int st_kind, st_pwm0, st_pwm_end, st_done, st_len, st_end;
  int st_shift, st_rise, st_latch, st_mode_bad, st_pwm_bad;
  int sum_len;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset)
      check_val("strobe_excl",
                int'(bus.load_led_vals) + int'(bus.load_brightness) + int'(bus.shift) > 1, 0);
    if (bus.pwm_cycle_done) done_count++;
  end

  // Starts on the LOAD cycle. Ends on the next LOAD cycle, or on the first idle cycle.
  task automatic watch_step(input int req_at, input int drop_at);
    int prev_sclk;
    int mode0;
    st_kind     = bus.load_brightness ? 1 : (bus.load_led_vals ? 0 : 2);
    st_pwm0     = int'(bus.pwm_time);
    mode0       = int'(bus.mode_sel);
    prev_sclk   = int'(bus.serial_clk);
    st_len      = 0;
    st_shift    = 0;
    st_rise     = 0;
    st_latch    = 0;
    st_mode_bad = 0;
    st_pwm_bad  = 0;
    st_end      = 0;
    st_pwm_end  = -1;
    st_done     = -1;
    for (int i = 0; i < 200; i++) begin
      if (i == req_at) bus.brightness_req = 1'b1;
      if (i == drop_at) bus.enable = 1'b0;
      @(negedge clk);
      bus.brightness_req = 1'b0;
      st_len++;
      if (bus.load_led_vals || bus.load_brightness || !bus.busy) begin
        st_pwm_end = int'(bus.pwm_time);
        st_done    = int'(bus.pwm_cycle_done);
        st_end     = 1;
        break;
      end
      if (bus.shift) st_shift++;
      if (bus.serial_clk && prev_sclk == 0) st_rise++;
      prev_sclk = int'(bus.serial_clk);
      if (bus.latch) st_latch++;
      if (int'(bus.mode_sel) != mode0) st_mode_bad++;
      if (int'(bus.pwm_time) != st_pwm0) st_pwm_bad++;
    end
    if (st_end == 0) check_val("step_timeout", 1, 0);
    $display("step kind=%0d pwm=%0d->%0d len=%0d shifts=%0d rises=%0d latch=%0d done=%0d",
             st_kind, st_pwm0, st_pwm_end, st_len, st_shift, st_rise, st_latch, st_done);
  endtask

  task automatic check_step(input string tag, input int kind, input int pwm0,
                            input int pwm_end, input int done);
    check_val({tag, "_kind"}, st_kind, kind);
    check_val({tag, "_pwm0"}, st_pwm0, pwm0);
    check_val({tag, "_pwm_end"}, st_pwm_end, pwm_end);
    check_val({tag, "_done"}, st_done, done);
    check_val({tag, "_len"}, st_len, 67);
    check_val({tag, "_shifts"}, st_shift, 16);
    check_val({tag, "_rises"}, st_rise, 16);
    check_val({tag, "_latch"}, st_latch, 2);
    check_val({tag, "_mode_hold"}, st_mode_bad, 0);
    check_val({tag, "_pwm_hold"}, st_pwm_bad, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.brightness_req = 1'b0;
    repeat (3) @(negedge clk);

    check_val("rst_busy", bus.busy, 0);
    check_val("rst_pwm", bus.pwm_time, 0);
    check_val("rst_latch", bus.latch, 0);
    check_val("rst_sclk", bus.serial_clk, 0);
    check_val("rst_strobes", int'(bus.load_led_vals) + int'(bus.load_brightness) + int'(bus.shift), 0);
    check_val("rst_mode", bus.mode_sel, 0);

    // 1: the first step after reset carries brightness
    reset = 1'b0;
    @(negedge clk);
    check_val("t1_lb", bus.load_brightness, 1);
    check_val("t1_lv", bus.load_led_vals, 0);
    check_val("t1_mode", bus.mode_sel, 1);
    watch_step(-1, -1);
    check_step("t1_bri", 1, 0, 0, 0);
    check_val("t1_next_lv", bus.load_led_vals, 1);
    check_val("t1_next_mode", bus.mode_sel, 0);

    // 2: a full PWM cycle of LED steps
    sum_len = 0;
    for (int k = 0; k < 256; k++) begin
      watch_step(-1, -1);
      sum_len += st_len;
      check_step("t2_led", 0, k, (k + 1) % 256, (k == 255) ? 1 : 0);
    end
    check_val("t2_cycle_len", sum_len, 17152);

    // 3: brightness request mid-shift at pwm_time=10
    for (int k = 0; k < 10; k++) begin
      watch_step(-1, -1);
      check_step("t3_pre", 0, k, k + 1, 0);
    end
    check_val("t3_done_count", done_count, 1);
    watch_step(20, -1);
    check_step("t3_req_step", 0, 10, 11, 0);
    watch_step(-1, -1);
    check_step("t3_bri", 1, 11, 11, 0);
    watch_step(-1, -1);
    check_step("t3_led", 0, 11, 12, 0);

    // 4: one request mid-step, one coincident with the brightness LOAD
    watch_step(30, -1);
    check_step("t4_led", 0, 12, 13, 0);
    watch_step(0, -1);
    check_step("t4_bri_a", 1, 13, 13, 0);
    watch_step(-1, -1);
    check_step("t4_bri_b", 1, 13, 13, 0);

    // 5: enable dropped during SHIFT_HI of bit 5
    watch_step(-1, 23);
    check_step("t5_led", 0, 13, 14, 0);
    check_val("t5_busy", bus.busy, 0);
    repeat (3) begin
      @(negedge clk);
      check_val("t5_idle_busy", bus.busy, 0);
      check_val("t5_idle_pwm", bus.pwm_time, 14);
    end
    bus.enable = 1'b1;
    @(negedge clk);
    check_val("t5_reload_lv", bus.load_led_vals, 1);
    check_val("t5_reload_busy", bus.busy, 1);

    // 6: reset asserted during LATCH
    begin
      int found;
      found = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (bus.latch) begin
          found = 1;
          break;
        end
      end
      check_val("t6_latch_seen", found, 1);
    end
    reset = 1'b1;
    #1;
    check_val("t6_latch", bus.latch, 0);
    check_val("t6_sclk", bus.serial_clk, 0);
    check_val("t6_busy", bus.busy, 0);
    check_val("t6_pwm", bus.pwm_time, 0);
    check_val("t6_mode", bus.mode_sel, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("t6_lb", bus.load_brightness, 1);
    watch_step(-1, -1);
    check_step("t6_bri", 1, 0, 0, 0);
    check_val("t6_next_lv", bus.load_led_vals, 1);
    check_val("final_done_count", done_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/led_frame_sequencer.md
Name: led_frame_sequencer

Overview:
- Timing master that sits directly upstream of the color component drivers and controls all of them in lockstep.
- It steps the shared 8-bit PWM time base and issues the load_led_vals / load_brightness / shift pulses the driver shift registers consume.
- It generates the serial clock and latch strobes for the LED driver chips downstream of those shift registers.
- One complete load–shift–latch sequence is a "step"; 256 steps form one PWM cycle.

Parameters:
SHIFT_BITS, 16, bits shifted per step (driver shift-register width)
CLK_DIV, 2, clk cycles per serial_clk half-period (>=1)
LATCH_CYCLES, 2, clk cycles latch is held high (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  run request; sampled in IDLE and at end of each step
brightness_req  input  1  one-cycle pulse: reload brightness into drivers
pwm_time  output  8  PWM time base to driver comparators
load_led_vals  output  1  one-cycle strobe: drivers capture PWM compare bits
load_brightness  output  1  one-cycle strobe: drivers capture brightness word
shift  output  1  one-cycle strobe: drivers advance serial output one bit
serial_clk  output  1  serial clock to LED driver chips
latch  output  1  latch strobe to LED driver chips
mode_sel  output  1  1 = current step carries brightness data
busy  output  1  high in every state except IDLE
pwm_cycle_done  output  1  one-cycle pulse when pwm_time wraps 255->0

Behaviour:
- Reset (async, high):
  - state=IDLE, pwm_time=0; all strobes, serial_clk, latch, mode_sel, busy, pwm_cycle_done =0.
  - brightness_pending=1, so the first step after reset is a brightness step.
- All outputs are registered.
- States: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE:
  - enable=1 -> LOAD on the next edge.
  - Otherwise stay in IDLE.
- LOAD (1 cycle):
  - If brightness_pending=1: load_brightness=1, mode_sel set 1 and held for the whole step, pending cleared.
  - Else: load_led_vals=1, mode_sel=0.
  - Next state: SHIFT_LO with bit_cnt=0.
- SHIFT_LO: serial_clk=0 for CLK_DIV cycles, then SHIFT_HI.
- SHIFT_HI:
  - serial_clk=1 for CLK_DIV cycles; downstream samples on the serial_clk rising edge.
  - On the last SHIFT_HI cycle: shift=1 for exactly one cycle and bit_cnt increments.
  - If bit_cnt was SHIFT_BITS-1 -> LATCH; else -> SHIFT_LO.
- Pulse counts per step: exactly SHIFT_BITS shift pulses and SHIFT_BITS serial_clk rising edges.
- LATCH:
  - latch=1 for LATCH_CYCLES cycles; serial_clk=0.
  - On the last LATCH cycle, LED steps only (mode_sel=0): pwm_time increments modulo 256. On the 255->0 wrap, pwm_cycle_done=1 in the following cycle.
  - Brightness steps leave pwm_time unchanged.
  - Next state: LOAD if enable=1, else IDLE.
- Step length: 1 + SHIFT_BITS*2*CLK_DIV + LATCH_CYCLES cycles (67 with defaults). There are no idle gaps between consecutive steps.
- enable deasserted mid-step: the step completes; the sequencer enters IDLE after LATCH. It never aborts mid-shift.
- brightness_req:
  - Sets pending on any cycle.
  - If it arrives in the same cycle as a brightness LOAD, set wins and pending stays 1.
  - Multiple requests before service collapse into one brightness step.
- pwm_time is stable from LOAD through the end of LATCH. It changes only at the LATCH->next-step boundary.
- Mutual exclusion: load_led_vals, load_brightness and shift are never high in the same cycle.
- Reset asserted mid-step: all outputs drop immediately (asynchronously); a brightness step is the first step after release.

Test Plan:
1. Release reset with enable=1 -> the first LOAD asserts load_brightness (not load_led_vals), mode_sel=1, 16 shift pulses, latch high 2 cycles, pwm_time stays 0. The next step asserts load_led_vals.
2. Run LED steps continuously -> each step is 67 cycles and pwm_time counts 0,1,2… After the step at pwm_time=255 it reads 0 and pwm_cycle_done pulses once. A 256-step cycle is 17152 cycles.
3. Pulse brightness_req at pwm_time=10 mid-shift -> the step completes normally and pwm_time goes to 11. The next step is a brightness step with pwm_time held at 11; the step after it is LED at 11.
4. Two brightness_req pulses, one of them coincident with the brightness LOAD -> exactly two brightness steps occur, then LED steps resume.
5. Drop enable during SHIFT_HI of bit 5 -> the remaining 11 shifts and the latch complete, then IDLE with busy=0 and pwm_time incremented by 1. Re-raising enable gives LOAD on the next cycle.
6. Assert reset during LATCH -> latch, serial_clk and busy are 0 immediately and pwm_time=0. After release, the first step is a brightness step. Checked on every cycle: no two strobes are high at once.
